// File: rtl/cache_fsm_l2c_if.sv
// L1-side request/acknowledge bus plus the main-memory handshake of the L2 responder.
// The slave modport is the cache's view. The master modport is the view of L1 plus memory.
interface cache_fsm_l2c_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LINE_WIDTH    = 128
);
  // L1 side
  logic [ADDRESS_WIDTH-1:0] cache_L2_memory_address;
  logic                     read_from_L2_request;
  logic                     write_to_L2_request;
  logic                     write_back_to_L2_request;
  logic [DATA_WIDTH-1:0]    write_word_to_L2;
  logic [LINE_WIDTH-1:0]    write_back_to_L2_data;
  logic [LINE_WIDTH-1:0]    write_data_to_L1_from_L2;
  logic                     L2_ready;
  logic                     write_to_L2_verified;
  logic                     write_back_to_L2_verified;
  logic                     L2_cache_hit;
  logic                     L2_cache_miss;
  // Main-memory side
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_read_request;
  logic [LINE_WIDTH-1:0]    mem_read_data;
  logic                     mem_read_valid;
  logic                     mem_write_request;
  logic [LINE_WIDTH-1:0]    mem_write_data;
  logic                     mem_write_done;

  modport slave (
    input  cache_L2_memory_address, read_from_L2_request, write_to_L2_request,
           write_back_to_L2_request, write_word_to_L2, write_back_to_L2_data,
           mem_read_data, mem_read_valid, mem_write_done,
    output write_data_to_L1_from_L2, L2_ready, write_to_L2_verified,
           write_back_to_L2_verified, L2_cache_hit, L2_cache_miss,
           mem_address, mem_read_request, mem_write_request, mem_write_data
  );

  modport master (
    output cache_L2_memory_address, read_from_L2_request, write_to_L2_request,
           write_back_to_L2_request, write_word_to_L2, write_back_to_L2_data,
           mem_read_data, mem_read_valid, mem_write_done,
    input  write_data_to_L1_from_L2, L2_ready, write_to_L2_verified,
           write_back_to_L2_verified, L2_cache_hit, L2_cache_miss,
           mem_address, mem_read_request, mem_write_request, mem_write_data
  );
endinterface

// File: rtl/cache_fsm_l2c.sv
// Direct-mapped, write-back, write-allocate L2 responder for L1 line reads, word writes
// and dirty-line write-backs. Misses are resolved through held-request memory handshakes.
// All outputs are registered.
module cache_fsm_l2c #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LINE_WIDTH    = 128,
  parameter int unsigned NUM_SETS      = 16
) (
  input logic            clk,
  input logic            reset,
  cache_fsm_l2c_if.slave bus
);
  localparam int unsigned ByteW     = $clog2(LINE_WIDTH / 8);
  localparam int unsigned WordByteW = $clog2(DATA_WIDTH / 8);
  localparam int unsigned SelW      = $clog2(LINE_WIDTH / DATA_WIDTH);
  localparam int unsigned IdxW      = $clog2(NUM_SETS);
  // The top two address bits are the processor id and are not part of the tag.
  localparam int unsigned TagW      = ADDRESS_WIDTH - 2 - ByteW - IdxW;
  localparam logic [ADDRESS_WIDTH-1:0] AlignMask =
      {{(ADDRESS_WIDTH - ByteW){1'b1}}, {ByteW{1'b0}}};

  typedef enum logic [2:0] {StIdle, StLookup, StEvict, StFill, StUpdate, StDone} state_e;
  typedef enum logic [1:0] {ReqRead, ReqWord, ReqWb} req_e;

  state_e                   state_q, state_d;
  req_e                     type_q, type_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
  logic [LINE_WIDTH-1:0]    wb_line_q, wb_line_d;

  // Line storage: valid/dirty are reset, payload is not.
  logic [NUM_SETS-1:0]      valid_q, dirty_q;
  logic [TagW-1:0]          tag_q   [NUM_SETS];
  logic [LINE_WIDTH-1:0]    line_q  [NUM_SETS];
  logic [ADDRESS_WIDTH-1:0] laddr_q [NUM_SETS];

  // Registered outputs.
  logic [LINE_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     ready_q, ready_d;
  logic                     wr_ack_q, wr_ack_d;
  logic                     wb_ack_q, wb_ack_d;
  logic                     hit_q, hit_d;
  logic                     miss_q, miss_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                     mem_rd_q, mem_rd_d;
  logic                     mem_wr_q, mem_wr_d;
  logic [LINE_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

  // Array write controls.
  logic                  line_we;
  logic [LINE_WIDTH-1:0] line_wd;
  logic                  meta_we;
  logic                  dirty_we;
  logic                  dirty_wd;

  logic [IdxW-1:0] idx;
  logic [TagW-1:0] tag;
  logic [SelW-1:0] sel;
  logic            hit;

  assign idx = addr_q[ByteW +: IdxW];
  assign tag = addr_q[ADDRESS_WIDTH-3 -: TagW];
  assign sel = addr_q[WordByteW +: SelW];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  // Next state, next registered outputs and array write controls.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    word_d      = word_q;
    wb_line_d   = wb_line_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    wr_ack_d    = 1'b0;
    wb_ack_d    = 1'b0;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_wdata_d = mem_wdata_q;
    line_we     = 1'b0;
    line_wd     = line_q[idx];
    meta_we     = 1'b0;
    dirty_we    = 1'b0;
    dirty_wd    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.write_back_to_L2_request || bus.write_to_L2_request ||
            bus.read_from_L2_request) begin
          addr_d    = bus.cache_L2_memory_address;
          word_d    = bus.write_word_to_L2;
          wb_line_d = bus.write_back_to_L2_data;
          if (bus.write_back_to_L2_request) begin
            type_d = ReqWb;
          end else if (bus.write_to_L2_request) begin
            type_d = ReqWord;
          end else begin
            type_d = ReqRead;
          end
          state_d = StLookup;
        end
      end
      StLookup: begin
        hit_d  = hit;
        miss_d = !hit;
        if (hit) begin
          state_d = StUpdate;
        end else if (dirty_q[idx]) begin
          state_d     = StEvict;
          mem_wr_d    = 1'b1;
          mem_addr_d  = laddr_q[idx] & AlignMask;
          mem_wdata_d = line_q[idx];
        end else if (type_q == ReqWb) begin
          // A full-line write-back needs no fill.
          state_d = StUpdate;
        end else begin
          state_d    = StFill;
          mem_rd_d   = 1'b1;
          mem_addr_d = addr_q & AlignMask;
        end
      end
      StEvict: begin
        if (bus.mem_write_done) begin
          mem_wr_d = 1'b0;
          dirty_we = 1'b1;
          dirty_wd = 1'b0;
          if (type_q == ReqWb) begin
            state_d = StUpdate;
          end else begin
            state_d    = StFill;
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_q & AlignMask;
          end
        end
      end
      StFill: begin
        if (bus.mem_read_valid) begin
          mem_rd_d = 1'b0;
          line_we  = 1'b1;
          line_wd  = bus.mem_read_data;
          meta_we  = 1'b1;
          dirty_we = 1'b1;
          dirty_wd = 1'b0;
          state_d  = StUpdate;
        end
      end
      StUpdate: begin
        unique case (type_q)
          ReqRead: begin
            rdata_d = line_q[idx];
            ready_d = 1'b1;
          end
          ReqWord: begin
            line_wd[sel*DATA_WIDTH +: DATA_WIDTH] = word_q;
            line_we  = 1'b1;
            dirty_we = 1'b1;
            dirty_wd = 1'b1;
            wr_ack_d = 1'b1;
          end
          ReqWb: begin
            line_wd  = wb_line_q;
            line_we  = 1'b1;
            meta_we  = 1'b1;
            dirty_we = 1'b1;
            dirty_wd = 1'b1;
            wb_ack_d = 1'b1;
          end
          default: ;
        endcase
        state_d = StDone;
      end
      // Requests are ignored here so a still-held request is not serviced twice.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      type_q      <= ReqRead;
      addr_q      <= '0;
      word_q      <= '0;
      wb_line_q   <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      wr_ack_q    <= 1'b0;
      wb_ack_q    <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      wb_line_q   <= wb_line_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      wr_ack_q    <= wr_ack_d;
      wb_ack_q    <= wb_ack_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Valid and dirty bits, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (meta_we) valid_q[idx] <= 1'b1;
      if (dirty_we) dirty_q[idx] <= dirty_wd;
    end
  end

  // Line payload, tag and eviction address.
  always_ff @(posedge clk) begin
    if (line_we) line_q[idx] <= line_wd;
    if (meta_we) begin
      tag_q[idx]   <= tag;
      laddr_q[idx] <= addr_q;
    end
  end

  assign bus.write_data_to_L1_from_L2  = rdata_q;
  assign bus.L2_ready                  = ready_q;
  assign bus.write_to_L2_verified      = wr_ack_q;
  assign bus.write_back_to_L2_verified = wb_ack_q;
  assign bus.L2_cache_hit              = hit_q;
  assign bus.L2_cache_miss             = miss_q;
  assign bus.mem_address               = mem_addr_q;
  assign bus.mem_read_request          = mem_rd_q;
  assign bus.mem_write_request         = mem_wr_q;
  assign bus.mem_write_data            = mem_wdata_q;
endmodule

// File: tb/tb_cache_fsm_l2c.sv
// Directed bench for cache_fsm_l2c: plays L1 and a main-memory responder with a
// programmable acknowledge delay, and checks against hand-computed expectations.
module tb_cache_fsm_l2c;
  localparam int KRead = 0;
  localparam int KWord = 1;
  localparam int KWb   = 2;

  localparam logic [127:0] L0  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] L0M = 128'h1111_2222_3333_4444_DEAD_BEEF_7777_8888;
  localparam logic [127:0] L1  = 128'h0123_4567_89AB_CDEF_0F0F_0F0F_F0F0_F0F0;
  localparam logic [127:0] LA  = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam logic [127:0] L2  = 128'hCAFE_0000_CAFE_1111_CAFE_2222_CAFE_3333;

  logic clk;
  logic reset;

  cache_fsm_l2c_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .LINE_WIDTH(128)) bus ();

  cache_fsm_l2c #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .LINE_WIDTH   (128),
    .NUM_SETS     (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Observations of the last transaction.
  int           hit_cnt, miss_cnt, rd_cnt, wr_cnt, cycles, ack_extra, req_extra;
  bit           wr_first, acked;
  int           mem_delay;
  logic [31:0]  rd_addr, wr_addr;
  logic [127:0] wr_data, got_line;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drop_requests();
    bus.read_from_L2_request     = 1'b0;
    bus.write_to_L2_request      = 1'b0;
    bus.write_back_to_L2_request = 1'b0;
  endtask

  // Issue one L1 request and act as memory until the matching acknowledge arrives.
  task automatic run_req(input int kind, input logic [31:0] addr, input logic [31:0] word,
                         input logic [127:0] line, input logic [127:0] fill);
    int rd_wait = 0;
    int wr_wait = 0;
    logic ack;
    hit_cnt = 0; miss_cnt = 0; rd_cnt = 0; wr_cnt = 0; cycles = 0;
    ack_extra = 0; req_extra = 0; wr_first = 0; acked = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; got_line = '0;
    @(negedge clk);
    bus.cache_L2_memory_address = addr;
    bus.write_word_to_L2        = word;
    bus.write_back_to_L2_data   = line;
    case (kind)
      KRead:   bus.read_from_L2_request = 1'b1;
      KWord:   bus.write_to_L2_request = 1'b1;
      default: bus.write_back_to_L2_request = 1'b1;
    endcase
    for (int k = 1; k <= 60 && !acked; k++) begin
      @(negedge clk);
      hit_cnt  += int'(bus.L2_cache_hit);
      miss_cnt += int'(bus.L2_cache_miss);
      if (bus.mem_write_done) begin
        bus.mem_write_done = 1'b0;
      end else if (bus.mem_write_request) begin
        if (wr_wait < mem_delay) begin
          wr_wait++;
        end else begin
          wr_wait = 0;
          bus.mem_write_done = 1'b1;
          wr_cnt++;
          wr_addr = bus.mem_address;
          wr_data = bus.mem_write_data;
        end
      end
      if (bus.mem_read_valid) begin
        bus.mem_read_valid = 1'b0;
      end else if (bus.mem_read_request) begin
        if (rd_wait < mem_delay) begin
          rd_wait++;
        end else begin
          rd_wait = 0;
          bus.mem_read_valid = 1'b1;
          bus.mem_read_data  = fill;
          rd_cnt++;
          rd_addr = bus.mem_address;
          if (wr_cnt > 0) wr_first = 1'b1;
        end
      end
      case (kind)
        KRead:   ack = bus.L2_ready;
        KWord:   ack = bus.write_to_L2_verified;
        default: ack = bus.write_back_to_L2_verified;
      endcase
      if (ack) begin
        acked    = 1'b1;
        cycles   = k;
        got_line = bus.write_data_to_L1_from_L2;
        drop_requests();
      end
    end
    bus.mem_read_valid = 1'b0;
    bus.mem_write_done = 1'b0;
    check_eq("ack_seen", 128'(acked), 128'd1);
    // Acknowledges are single pulses and memory requests must have dropped.
    repeat (3) begin
      @(negedge clk);
      ack_extra += int'(bus.L2_ready) + int'(bus.write_to_L2_verified) +
                   int'(bus.write_back_to_L2_verified);
      req_extra += int'(bus.mem_read_request) + int'(bus.mem_write_request);
    end
    drop_requests();
  endtask

  initial begin
    reset = 1'b1;
    mem_delay = 0;
    drop_requests();
    bus.cache_L2_memory_address = '0;
    bus.write_word_to_L2        = '0;
    bus.write_back_to_L2_data   = '0;
    bus.mem_read_data           = '0;
    bus.mem_read_valid          = 1'b0;
    bus.mem_write_done          = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 128'(bus.L2_ready), 128'd0);
    check_eq("rst_mem_rd", 128'(bus.mem_read_request), 128'd0);
    check_eq("rst_rdata", bus.write_data_to_L1_from_L2, 128'd0);
    reset = 1'b0;

    // Cold read miss, memory acknowledges in the first request cycle.
    run_req(KRead, 32'h8000_0040, 32'h0, 128'h0, L0);
    check_eq("t1_miss", 128'(miss_cnt), 128'd1);
    check_eq("t1_hit", 128'(hit_cnt), 128'd0);
    check_eq("t1_rd_cnt", 128'(rd_cnt), 128'd1);
    check_eq("t1_wr_cnt", 128'(wr_cnt), 128'd0);
    check_eq("t1_rd_addr", 128'(rd_addr), 128'h8000_0040);
    check_eq("t1_line", got_line, L0);
    check_eq("t1_cycles", 128'(cycles), 128'd4);
    check_eq("t1_extra", 128'(ack_extra + req_extra), 128'd0);

    // Read hit.
    run_req(KRead, 32'h8000_0040, 32'h0, 128'h0, L1);
    check_eq("t2_hit", 128'(hit_cnt), 128'd1);
    check_eq("t2_miss", 128'(miss_cnt), 128'd0);
    check_eq("t2_mem", 128'(rd_cnt + wr_cnt), 128'd0);
    check_eq("t2_cycles", 128'(cycles), 128'd3);
    check_eq("t2_line", got_line, L0);

    // Word write hit into word 1.
    run_req(KWord, 32'h8000_0044, 32'hDEAD_BEEF, 128'h0, L1);
    check_eq("t3_hit", 128'(hit_cnt), 128'd1);
    check_eq("t3_mem", 128'(rd_cnt + wr_cnt), 128'd0);
    check_eq("t3_cycles", 128'(cycles), 128'd3);
    check_eq("t3_extra", 128'(ack_extra), 128'd0);

    run_req(KRead, 32'h8000_0040, 32'h0, 128'h0, L1);
    check_eq("t4_line", got_line, L0M);
    check_eq("t4_hit", 128'(hit_cnt), 128'd1);

    // Conflict read: dirty victim written back before the fill, one-cycle memory delay.
    mem_delay = 1;
    run_req(KRead, 32'h8000_0440, 32'h0, 128'h0, L1);
    check_eq("t5_miss", 128'(miss_cnt), 128'd1);
    check_eq("t5_wr_cnt", 128'(wr_cnt), 128'd1);
    check_eq("t5_wr_addr", 128'(wr_addr), 128'h8000_0040);
    check_eq("t5_wr_data", wr_data, L0M);
    check_eq("t5_order", 128'(wr_first), 128'd1);
    check_eq("t5_rd_addr", 128'(rd_addr), 128'h8000_0440);
    check_eq("t5_line", got_line, L1);
    check_eq("t5_cycles", 128'(cycles), 128'd7);
    mem_delay = 0;

    // Write-back over a clean victim: no fill.
    run_req(KWb, 32'h8000_0840, 32'h0, LA, L2);
    check_eq("t6_miss", 128'(miss_cnt), 128'd1);
    check_eq("t6_mem", 128'(rd_cnt + wr_cnt), 128'd0);
    check_eq("t6_cycles", 128'(cycles), 128'd3);

    // Conflicting read evicts the written-back line.
    run_req(KRead, 32'h8000_0040, 32'h0, 128'h0, L2);
    check_eq("t7_wr_addr", 128'(wr_addr), 128'h8000_0840);
    check_eq("t7_wr_data", wr_data, LA);
    check_eq("t7_rd_cnt", 128'(rd_cnt), 128'd1);
    check_eq("t7_line", got_line, L2);
    check_eq("t7_cycles", 128'(cycles), 128'd5);

    // Reset in the middle of a fill.
    @(negedge clk);
    bus.cache_L2_memory_address = 32'h8000_0140;
    bus.read_from_L2_request    = 1'b1;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        seen = bus.mem_read_request;
      end
      check_eq("t8_fill_req", 128'(seen), 128'd1);
    end
    reset = 1'b1;
    drop_requests();
    #1;
    check_eq("t8_mem_rd", 128'(bus.mem_read_request), 128'd0);
    check_eq("t8_mem_addr", 128'(bus.mem_address), 128'd0);
    check_eq("t8_rdata", bus.write_data_to_L1_from_L2, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    ack_extra = 0;
    req_extra = 0;
    repeat (5) begin
      @(negedge clk);
      ack_extra += int'(bus.L2_ready) + int'(bus.write_to_L2_verified) +
                   int'(bus.write_back_to_L2_verified);
      req_extra += int'(bus.mem_read_request) + int'(bus.mem_write_request);
    end
    check_eq("t8_no_ack", 128'(ack_extra + req_extra), 128'd0);

    // Previously cached line must now miss.
    run_req(KRead, 32'h8000_0040, 32'h0, 128'h0, L0);
    check_eq("t9_miss", 128'(miss_cnt), 128'd1);
    check_eq("t9_wr_cnt", 128'(wr_cnt), 128'd0);
    check_eq("t9_rd_cnt", 128'(rd_cnt), 128'd1);
    check_eq("t9_line", got_line, L0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
